// File: rtl/apb_reg_completer.sv
// APB3 completer: NUM_REGS x DATA_W register file (reg 0 = read-only ID), exported to peripheral logic.
// Latency: setup + WAIT_STATES+1 access cycles; stalls the requester with pready low while the wait counter drains.
module apb_reg_completer #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_pulse,
  output logic [5:0]                   wr_idx
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d, phase;
  logic [3:0]          cnt_q, cnt_d;
  logic                capture, commit;
  logic [IDX_W-1:0]    req_idx;
  logic                req_err;
  logic [IDX_W-1:0]    cap_idx_q;
  logic                cap_write_q;
  logic                cap_err_q;
  logic [DATA_W-1:0]   cap_wdata_q;
  logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   rd_val;

  assign req_idx = paddr[ADDR_W-1:2];
  assign req_err = (paddr[1:0] != 2'b00) ||
                   (req_idx >= IDX_W'(NUM_REGS)) ||
                   (pwrite && (req_idx == '0));

  // SETUP is never stored: an IDLE cycle with psel high is the setup phase itself,
  // which is what allows back-to-back transfers without an idle cycle.
  always_comb begin
    phase   = state_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    pready  = 1'b0;
    if (state_q == IDLE && psel) phase = SETUP;
    case (phase)
      SETUP: begin
        capture = 1'b1;
        cnt_d   = 4'(WAIT_STATES);
        state_d = ACCESS;
      end
      ACCESS: begin
        pready = (cnt_q == 4'd0) && penable;
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          commit  = cap_write_q && !cap_err_q;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cap_idx_q   <= '0;
      cap_write_q <= 1'b0;
      cap_err_q   <= 1'b0;
      cap_wdata_q <= '0;
      wr_pulse    <= 1'b0;
      wr_idx      <= 6'd0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_pulse <= commit;
      if (capture) begin
        cap_idx_q   <= req_idx;
        cap_write_q <= pwrite;
        cap_err_q   <= req_err;
        cap_wdata_q <= pwdata;
      end
      if (commit) wr_idx <= cap_idx_q[5:0];
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit && (cap_idx_q == IDX_W'(i))) regs_q[i] <= cap_wdata_q;
      end
    end
  end

  // Index 0 falls through to the ID; out-of-range indices are masked by cap_err_q.
  always_comb begin
    rd_val = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (cap_idx_q == IDX_W'(i)) rd_val = regs_q[i];
    end
  end

  assign prdata  = (pready && !cap_err_q) ? rd_val : '0;
  assign pslverr = pready && cap_err_q;

  always_comb begin
    regs_out = '0;
    regs_out[DATA_W-1:0] = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) regs_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: three instances (WAIT_STATES 1, 0, 3) on one shared APB bus, separate psel each.
module tb_apb_reg_completer;

  localparam int          NDUT = 3;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic         psel     [NDUT];
  logic [31:0]  prdata   [NDUT];
  logic         pready   [NDUT];
  logic         pslverr  [NDUT];
  logic [255:0] regs_out [NDUT];
  logic         wr_pulse [NDUT];
  logic [5:0]   wr_idx   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_reg_completer #(
      .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .psel     (psel[g]),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata[g]),
      .pready   (pready[g]),
      .pslverr  (pslverr[g]),
      .regs_out (regs_out[g]),
      .wr_pulse (wr_pulse[g]),
      .wr_idx   (wr_idx[g])
    );
  end

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int pulse_cnt [NDUT] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    bit          wr;
    bit          pulse;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [NDUT][8];

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 0 : 3;
  endfunction

  function automatic bit addr_err(input bit wr, input logic [11:0] a);
    return (a[1:0] != 2'b00) || (a[11:2] >= 10'd8) || (wr && a[11:2] == 10'd0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; leaving psel low lets a following call start with no idle cycle.
  task automatic apb_xfer(input int d, input string tag, input bit wr, input logic [11:0] a,
                          input logic [31:0] wd, input bit pen_early);
    exp_t        e;
    exp_t        got;
    int          cyc;
    logic        rdy;
    logic        obs_err;
    logic [31:0] obs_rd;
    e.tag   = tag;
    e.wr    = wr;
    e.err   = addr_err(wr, a);
    e.cyc   = ws_of(d) + 1;
    e.pulse = wr && !e.err;
    e.rdata = e.err ? 32'h0 : mdl[d][a[4:2]];
    sb.push_back(e);
    psel[d] = 1'b1;
    penable = pen_early;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (pready[d] !== 1'b1 && cyc < 40);
    rdy     = pready[d];
    obs_rd  = prdata[d];
    obs_err = pslverr[d];
    @(posedge clk); #1;
    got = sb.pop_front();
    check({got.tag, ":pready"}, 32'(rdy), 32'd1);
    check({got.tag, ":wait"}, 32'(cyc), 32'(got.cyc));
    check({got.tag, ":pslverr"}, 32'(obs_err), 32'(got.err));
    if (!got.wr) check({got.tag, ":prdata"}, obs_rd, got.rdata);
    check({got.tag, ":wr_pulse"}, 32'(wr_pulse[d]), 32'(got.pulse));
    if (got.pulse) begin
      check({got.tag, ":wr_idx"}, 32'(wr_idx[d]), 32'(a[11:2]));
      mdl[d][a[4:2]] = wd;
    end
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 8; i++) mdl[d][i] = (i == 0) ? ID : 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    for (int d = 0; d < NDUT; d++) psel[d] = 1'b0;
    model_reset();

    // Reset state
    #2 rst = 1'b0;
    #2;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst%0d:pready", d), 32'(pready[d]), 32'd0);
      check($sformatf("rst%0d:pslverr", d), 32'(pslverr[d]), 32'd0);
      check($sformatf("rst%0d:prdata", d), prdata[d], 32'h0);
      check($sformatf("rst%0d:wr_pulse", d), 32'(wr_pulse[d]), 32'd0);
      check($sformatf("rst%0d:wr_idx", d), 32'(wr_idx[d]), 32'd0);
      check($sformatf("rst%0d:reg0", d), regs_out[d][31:0], ID);
      check($sformatf("rst%0d:reg1", d), regs_out[d][63:32], 32'h0);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // 1: ID read with one wait state
    apb_xfer(0, "t1_rd_id", 1'b0, 12'h000, 32'h0, 1'b0);

    // 2: write then read back reg 1
    p0 = pulse_cnt[0];
    apb_xfer(0, "t2_wr4", 1'b1, 12'h004, 32'hDEAD_BEEF, 1'b0);
    apb_xfer(0, "t2_rd4", 1'b0, 12'h004, 32'h0, 1'b0);
    check("t2:pulse_count", 32'(pulse_cnt[0]), 32'(p0 + 1));
    check("t2:regs_out1", regs_out[0][63:32], 32'hDEAD_BEEF);

    // 3: erroring accesses leave everything untouched
    p0 = pulse_cnt[0];
    apb_xfer(0, "t3_wr_id", 1'b1, 12'h000, 32'h1234_5678, 1'b0);
    apb_xfer(0, "t3_wr_oor", 1'b1, 12'h020, 32'h8765_4321, 1'b0);
    apb_xfer(0, "t3_rd_mis", 1'b0, 12'h006, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("t3:pulse_count", 32'(pulse_cnt[0]), 32'(p0));
    check("t3:regs_out0", regs_out[0][31:0], ID);
    check("t3:regs_out1", regs_out[0][63:32], 32'hDEAD_BEEF);
    apb_xfer(0, "t3_rd4", 1'b0, 12'h004, 32'h0, 1'b0);

    // 4: zero-wait back-to-back writes, then read back
    apb_xfer(1, "t4_wr8", 1'b1, 12'h008, 32'h1111_2222, 1'b0);
    apb_xfer(1, "t4_wrc", 1'b1, 12'h00C, 32'h3333_4444, 1'b0);
    apb_xfer(1, "t4_rd8", 1'b0, 12'h008, 32'h0, 1'b0);
    apb_xfer(1, "t4_rdc", 1'b0, 12'h00C, 32'h0, 1'b0);

    // 5: psel dropped in the first access cycle of a write
    p0 = pulse_cnt[1];
    psel[1] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h010;
    pwdata  = 32'h55AA_55AA;
    @(posedge clk); #1;
    psel[1] = 1'b0;
    penable = 1'b1;
    @(posedge clk); #1;
    penable = 1'b0;
    check("t5:wr_pulse", 32'(wr_pulse[1]), 32'd0);
    @(posedge clk); #1;
    check("t5:pulse_count", 32'(pulse_cnt[1]), 32'(p0));
    check("t5:regs_out4", regs_out[1][159:128], 32'h0);
    apb_xfer(1, "t5_rd10", 1'b0, 12'h010, 32'h0, 1'b0);

    // penable already high in the setup cycle still costs the full wait count
    apb_xfer(2, "t6_pen_idle", 1'b0, 12'h004, 32'h0, 1'b1);

    // 6: reset in the would-be completing cycle of a write
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h014;
    pwdata  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6:pre_rst_pready", 32'(pready[2]), 32'd1);
    rst = 1'b0;
    #1;
    check("t6:rst_pready", 32'(pready[2]), 32'd0);
    check("t6:rst_pslverr", 32'(pslverr[2]), 32'd0);
    check("t6:rst_wr_pulse", 32'(wr_pulse[2]), 32'd0);
    check("t6:rst_reg5", regs_out[2][191:160], 32'h0);
    check("t6:rst_other_reg1", regs_out[0][63:32], 32'h0);
    psel[2] = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    check("t6:wr_pulse_in_rst", 32'(wr_pulse[2]), 32'd0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    apb_xfer(2, "t6_rd14", 1'b0, 12'h014, 32'h0, 1'b0);
    apb_xfer(2, "t6_wr14", 1'b1, 12'h014, 32'h0BAD_CAFE, 1'b0);
    apb_xfer(2, "t6_rd14b", 1'b0, 12'h014, 32'h0, 1'b0);
    apb_xfer(0, "t6_rd4_cleared", 1'b0, 12'h004, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
